// File: rtl/ats21_cmd_arbiter.sv
// ats21_cmd_arbiter: front-end command arbiter for the ATS21 timer core.
// Two clients each build a 32-bit instruction from two 16-bit words. Full
// instructions are screened (conflicts, illegal opcodes, mode permissions),
// mode-register writes (opcode 011) are absorbed locally, and everything else
// is handed round-robin to a single valid/ready command port.
// Optional build macro: ATS21_ARB_TIMEOUT_EN drops a command that stalls for
// TIMEOUT_CYCLES cycles and Nacks its source.
module ats21_cmd_arbiter #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reqA,
  input  logic [15:0] ctrlA,
  input  logic        reqB,
  input  logic [15:0] ctrlB,
  output logic [1:0]  busy,
  output logic [1:0]  stat_valid,
  output logic [1:0]  stat,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [31:0] cmd_data,
  output logic        cmd_src
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HALF = 2'd1,
    ST_FULL = 2'd2
  } client_state_t;

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_MODE  = 3'b011;
  localparam logic [2:0] OP_ILLEG = 3'b100;

  // Client inputs gathered into indexable form (index 0 = A, 1 = B).
  logic [1:0]  w_req;
  logic [15:0] w_ctrl [2];

  assign w_req[0] = reqA;
  assign w_req[1] = reqB;
  assign w_ctrl[0] = ctrlA;
  assign w_ctrl[1] = ctrlB;

  // Status pulses, command register, round-robin pointer, mode register.
  logic [1:0]  r_stat_valid;
  logic [1:0]  r_stat;
  logic        r_cmd_valid;
  logic [31:0] r_cmd_data;
  logic        r_cmd_src;
  logic        r_rr_ptr;
  logic        r_active;
  logic [1:0]  r_clk_allow;
  logic [1:0]  r_alarm_allow;

  // Per-client view used by the arbiter.
  logic [1:0]  w_full;
  logic [1:0]  w_inflight;
  logic [1:0]  w_cand;
  logic [31:0] w_inst [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_client
      client_state_t r_state;
      logic [31:0]   r_inst;

      // Two-word assembly; a full slot is released by its own status pulse.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_state <= ST_IDLE;
          r_inst  <= '0;
        end else begin
          case (r_state)
            ST_IDLE: begin
              // Upper words with opcode 000 are nops and vanish silently.
              if (w_req[gi] && (w_ctrl[gi][15:13] != OP_NOP)) begin
                r_inst[31:16] <= w_ctrl[gi];
                r_state       <= ST_HALF;
              end
            end
            ST_HALF: begin
              if (w_req[gi]) begin
                r_inst[15:0] <= w_ctrl[gi];
                r_state      <= ST_FULL;
              end
            end
            ST_FULL: begin
              if (r_stat_valid[gi]) begin
                r_state <= ST_IDLE;
              end
            end
            default: r_state <= ST_IDLE;
          endcase
        end
      end

      assign w_full[gi]     = (r_state == ST_FULL);
      assign w_inst[gi]     = r_inst;
      assign w_inflight[gi] = r_cmd_valid && (r_cmd_src == 1'(gi));
      // A slot whose response is already on the wire is not re-arbitrated.
      assign w_cand[gi]     = w_full[gi] && !w_inflight[gi] && !r_stat_valid[gi];
    end
  endgenerate

  function automatic logic is_clk_op(input logic [2:0] op);
    return (op == 3'b001) || (op == 3'b010);
  endfunction

  function automatic logic is_alarm_op(input logic [2:0] op);
    return (op == 3'b101) || (op == 3'b110) || (op == 3'b111);
  endfunction

  logic [2:0] w_op0;
  logic [2:0] w_op1;
  logic       w_conflict;
  logic       w_accept;
  logic       w_arb_en;
  logic       w_both;
  logic       w_nack_both;
  logic       w_grant;
  logic       w_grant_src;
  logic [31:0] w_g_inst;
  logic [2:0] w_g_op;
  logic       w_g_local;
  logic       w_g_fwd;
  logic       w_to_fire;
  logic [1:0] w_sv_next;
  logic [1:0] w_st_next;

  assign w_op0 = w_inst[0][31:29];
  assign w_op1 = w_inst[1][31:29];

  // Pairs that target the same resource and cannot be ordered meaningfully.
  always_comb begin
    w_conflict = 1'b0;
    if ((w_op0 == OP_MODE) && (w_op1 == OP_MODE)) begin
      w_conflict = 1'b1;
    end
    if (is_clk_op(w_op0) && is_clk_op(w_op1) &&
        (w_inst[0][28:25] == w_inst[1][28:25])) begin
      w_conflict = 1'b1;
    end
    if (is_alarm_op(w_op0) && is_alarm_op(w_op1) &&
        (w_inst[0][28:24] == w_inst[1][28:24])) begin
      w_conflict = 1'b1;
    end
  end

  assign w_accept    = r_cmd_valid && cmd_ready;
  assign w_arb_en    = !r_cmd_valid || cmd_ready;
  assign w_both      = w_cand[0] && w_cand[1];
  assign w_nack_both = w_arb_en && w_both && w_conflict;
  assign w_grant     = w_arb_en && (w_cand != 2'b00) && !(w_both && w_conflict);
  // On a tie the client the pointer does not name wins.
  assign w_grant_src = w_both ? ~r_rr_ptr : w_cand[1];
  assign w_g_inst    = w_inst[w_grant_src];
  assign w_g_op      = w_g_inst[31:29];

  // Classify the granted instruction: local mode write, forward, or Nack.
  always_comb begin
    w_g_local = 1'b0;
    w_g_fwd   = 1'b0;
    if (w_g_op == OP_MODE) begin
      w_g_local = 1'b1;
    end else if (w_g_op == OP_ILLEG) begin
      w_g_fwd = 1'b0;
    end else if (!r_active) begin
      w_g_fwd = 1'b0;
    end else if (is_clk_op(w_g_op) && r_clk_allow[w_grant_src]) begin
      w_g_fwd = 1'b1;
    end else if (is_alarm_op(w_g_op) && r_alarm_allow[w_grant_src]) begin
      w_g_fwd = 1'b1;
    end
  end

`ifdef ATS21_ARB_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TO_W-1:0] r_to_cnt;

  assign w_to_fire = r_cmd_valid && !cmd_ready &&
                     (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  // Count consecutive stalled cycles of the command port.
  always_ff @(posedge clk) begin
    if (reset || !r_cmd_valid || cmd_ready || w_to_fire) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end
`else
  // Timeout disabled: the term is constant zero and only keeps the
  // parameter referenced.
  assign w_to_fire = (TIMEOUT_CYCLES < 0);
`endif

  // Next-cycle status pulses; the sources never target the same client.
  always_comb begin
    w_sv_next = 2'b00;
    w_st_next = 2'b00;
    if (w_accept) begin
      w_sv_next[r_cmd_src] = 1'b1;
      w_st_next[r_cmd_src] = 1'b1;
    end
    if (w_to_fire) begin
      w_sv_next[r_cmd_src] = 1'b1;
      w_st_next[r_cmd_src] = 1'b0;
    end
    if (w_nack_both) begin
      w_sv_next = 2'b11;
      w_st_next = 2'b00;
    end
    if (w_grant && !w_g_fwd) begin
      w_sv_next[w_grant_src] = 1'b1;
      w_st_next[w_grant_src] = w_g_local;
    end
  end

  // Register status pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stat_valid <= 2'b00;
      r_stat       <= 2'b00;
    end else begin
      r_stat_valid <= w_sv_next;
      r_stat       <= w_st_next;
    end
  end

  // Command register: cleared on accept/timeout, reloaded by a forward grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cmd_valid <= 1'b0;
      r_cmd_data  <= '0;
      r_cmd_src   <= 1'b0;
    end else begin
      if (w_accept || w_to_fire) begin
        r_cmd_valid <= 1'b0;
      end
      if (w_grant && w_g_fwd) begin
        r_cmd_valid <= 1'b1;
        r_cmd_data  <= w_g_inst;
        r_cmd_src   <= w_grant_src;
      end
    end
  end

  // Round-robin pointer follows every grant; resets to B so A wins first.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr <= 1'b1;
    end else if (w_grant) begin
      r_rr_ptr <= w_grant_src;
    end
  end

  // Mode register, written only by a granted opcode-011 instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_active      <= 1'b1;
      r_clk_allow   <= 2'b11;
      r_alarm_allow <= 2'b11;
    end else if (w_grant && w_g_local) begin
      r_active                   <= w_g_inst[28];
      r_alarm_allow[w_grant_src] <= w_g_inst[27];
      r_clk_allow[w_grant_src]   <= w_g_inst[25];
    end
  end

  assign busy       = w_full;
  assign stat_valid = r_stat_valid;
  assign stat       = r_stat;
  assign cmd_valid  = r_cmd_valid;
  assign cmd_data   = r_cmd_data;
  assign cmd_src    = r_cmd_src;

endmodule

// File: tb/tb_ats21_cmd_arbiter.sv
// Directed bench for ats21_cmd_arbiter with hand-computed expectations.
// Optional build macro: ATS21_ARB_TIMEOUT_EN adds the stall-timeout scenario.
module tb_ats21_cmd_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        reqA;
  logic [15:0] ctrlA;
  logic        reqB;
  logic [15:0] ctrlB;
  logic [1:0]  busy;
  logic [1:0]  stat_valid;
  logic [1:0]  stat;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_data;
  logic        cmd_src;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ats21_cmd_arbiter #(.TIMEOUT_CYCLES(15)) dut (
    .clk        (clk),
    .reset      (reset),
    .reqA       (reqA),
    .ctrlA      (ctrlA),
    .reqB       (reqB),
    .ctrlB      (ctrlB),
    .busy       (busy),
    .stat_valid (stat_valid),
    .stat       (stat),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_data   (cmd_data),
    .cmd_src    (cmd_src)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one word per client for exactly one edge.
  task automatic drive(input logic ra, input logic [15:0] ca,
                       input logic rb, input logic [15:0] cb);
    reqA = ra; ctrlA = ca; reqB = rb; ctrlB = cb;
    tick();
    reqA = 1'b0; ctrlA = 16'h0; reqB = 1'b0; ctrlB = 16'h0;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_stat(input string tag, input logic [1:0] sv, input logic [1:0] st);
    check({tag, ".stat_valid"}, 32'(stat_valid), 32'(sv));
    check({tag, ".stat"}, 32'(stat), 32'(st));
  endtask

  initial begin
    reset = 1'b1; cmd_ready = 1'b0;
    reqA = 1'b0; ctrlA = 16'h0; reqB = 1'b0; ctrlB = 16'h0;
    tick();
    tick();
    reset = 1'b0;

    $display("txn reset values");
    check("rst.busy", 32'(busy), 32'h0);
    check_stat("rst", 2'b00, 2'b00);
    check("rst.cmd_valid", 32'(cmd_valid), 32'h0);
    check("rst.cmd_data", cmd_data, 32'h0);
    check("rst.cmd_src", 32'(cmd_src), 32'h0);

    $display("txn A set clock 2 -> forwarded and Acked");
    cmd_ready = 1'b1;
    drive(1'b1, 16'h2400, 1'b0, 16'h0);
    check("a1.half_busy", 32'(busy), 32'h0);
    drive(1'b1, 16'h0005, 1'b0, 16'h0);
    check("a1.full_busy", 32'(busy), 32'h1);
    check("a1.cv_early", 32'(cmd_valid), 32'h0);
    tick();
    check("a1.cv", 32'(cmd_valid), 32'h1);
    check("a1.data", cmd_data, 32'h24000005);
    check("a1.src", 32'(cmd_src), 32'h0);
    check("a1.no_stat", 32'(stat_valid), 32'h0);
    tick();
    check("a1.cv_off", 32'(cmd_valid), 32'h0);
    check_stat("a1.ack", 2'b01, 2'b01);
    check("a1.busy_in_pulse", 32'(busy), 32'h1);
    tick();
    check("a1.sv_clear", 32'(stat_valid), 32'h0);
    check("a1.busy_drop", 32'(busy), 32'h0);

    $display("txn A/B same alarm -> conflict, Nack both");
    drive(1'b1, 16'hA300, 1'b1, 16'hA380);
    drive(1'b1, 16'h0000, 1'b1, 16'h0001);
    check("cf.busy", 32'(busy), 32'h3);
    tick();
    check_stat("cf.nack", 2'b11, 2'b00);
    check("cf.cv", 32'(cmd_valid), 32'h0);
    tick();
    check("cf.sv_clear", 32'(stat_valid), 32'h0);
    check("cf.busy_clear", 32'(busy), 32'h0);
    check("cf.cv2", 32'(cmd_valid), 32'h0);

    $display("txn A mode active=0 -> Ack, B clock -> Nack");
    drive(1'b1, 16'h6000, 1'b0, 16'h0);
    drive(1'b1, 16'h0000, 1'b0, 16'h0);
    tick();
    check_stat("md0.ack", 2'b01, 2'b01);
    check("md0.cv", 32'(cmd_valid), 32'h0);
    tick();
    drive(1'b0, 16'h0, 1'b1, 16'h2200);
    drive(1'b0, 16'h0, 1'b1, 16'h0007);
    tick();
    check_stat("inact.nack", 2'b10, 2'b00);
    check("inact.cv", 32'(cmd_valid), 32'h0);
    tick();

    $display("txn A mode active=1, A clk/alarm disallowed");
    drive(1'b1, 16'h7000, 1'b0, 16'h0);
    drive(1'b1, 16'h0000, 1'b0, 16'h0);
    tick();
    check_stat("md1.ack", 2'b01, 2'b01);
    tick();
    drive(1'b1, 16'h2400, 1'b0, 16'h0);
    drive(1'b1, 16'h0009, 1'b0, 16'h0);
    tick();
    check_stat("clkdis.nack", 2'b01, 2'b00);
    check("clkdis.cv", 32'(cmd_valid), 32'h0);
    tick();

    $display("txn B opcode 100 -> Nack");
    drive(1'b0, 16'h0, 1'b1, 16'h8000);
    drive(1'b0, 16'h0, 1'b1, 16'h0000);
    tick();
    check_stat("op100.nack", 2'b10, 2'b00);
    check("op100.cv", 32'(cmd_valid), 32'h0);
    tick();

    $display("txn B set clock 1 -> forwarded");
    drive(1'b0, 16'h0, 1'b1, 16'h2200);
    drive(1'b0, 16'h0, 1'b1, 16'h0007);
    tick();
    check("b1.cv", 32'(cmd_valid), 32'h1);
    check("b1.data", cmd_data, 32'h22000007);
    check("b1.src", 32'(cmd_src), 32'h1);
    tick();
    check_stat("b1.ack", 2'b10, 2'b10);
    tick();

    $display("txn B pending with cmd_ready=0, then reset");
    cmd_ready = 1'b0;
    drive(1'b0, 16'h0, 1'b1, 16'h2200);
    drive(1'b0, 16'h0, 1'b1, 16'h0001);
    tick();
    check("hold.cv", 32'(cmd_valid), 32'h1);
    check("hold.src", 32'(cmd_src), 32'h1);
    repeat (3) tick();
    check("hold.cv_later", 32'(cmd_valid), 32'h1);
    check("hold.data", cmd_data, 32'h22000001);
    check("hold.no_stat", 32'(stat_valid), 32'h0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mrst.cv", 32'(cmd_valid), 32'h0);
    check("mrst.data", cmd_data, 32'h0);
    check("mrst.src", 32'(cmd_src), 32'h0);
    check("mrst.busy", 32'(busy), 32'h0);
    check_stat("mrst", 2'b00, 2'b00);
    tick();
    check("mrst.no_late_pulse", 32'(stat_valid), 32'h0);

    cmd_ready = 1'b1;
    for (int r = 0; r < 3; r++) begin
      $display("txn round %0d: A clock 1 and B clock 2 together", r);
      drive(1'b1, 16'h2200, 1'b1, 16'h2400);
      drive(1'b1, 16'(r), 1'b1, 16'(16'h0100 + r));
      tick();
      check("rr.first_cv", 32'(cmd_valid), 32'h1);
      check("rr.first_src", 32'(cmd_src), 32'h0);
      check("rr.first_data", cmd_data, 32'h22000000 + 32'(r));
      tick();
      check("rr.second_cv", 32'(cmd_valid), 32'h1);
      check("rr.second_src", 32'(cmd_src), 32'h1);
      check("rr.second_data", cmd_data, 32'h24000100 + 32'(r));
      check_stat("rr.ackA", 2'b01, 2'b01);
      tick();
      check("rr.idle_cv", 32'(cmd_valid), 32'h0);
      check_stat("rr.ackB", 2'b10, 2'b10);
      tick();
    end

    $display("txn same clock from A then B -> serialised, not a conflict");
    drive(1'b1, 16'h2200, 1'b0, 16'h0);
    drive(1'b1, 16'h0003, 1'b1, 16'h2200);
    drive(1'b0, 16'h0, 1'b1, 16'h0004);
    check("seq.a_cv", 32'(cmd_valid), 32'h1);
    check("seq.a_src", 32'(cmd_src), 32'h0);
    check("seq.a_data", cmd_data, 32'h22000003);
    tick();
    check("seq.b_cv", 32'(cmd_valid), 32'h1);
    check("seq.b_src", 32'(cmd_src), 32'h1);
    check("seq.b_data", cmd_data, 32'h22000004);
    check_stat("seq.ackA", 2'b01, 2'b01);
    tick();
    check_stat("seq.ackB", 2'b10, 2'b10);
    check("seq.cv_off", 32'(cmd_valid), 32'h0);
    tick();

`ifdef ATS21_ARB_TIMEOUT_EN
    $display("txn B clock stalled -> timeout Nack");
    cmd_ready = 1'b0;
    drive(1'b0, 16'h0, 1'b1, 16'h2400);
    drive(1'b0, 16'h0, 1'b1, 16'h0002);
    tick();
    check("to.cv_start", 32'(cmd_valid), 32'h1);
    repeat (14) tick();
    check("to.cv_at_15", 32'(cmd_valid), 32'h1);
    check("to.no_stat_yet", 32'(stat_valid), 32'h0);
    tick();
    check("to.cv_drop", 32'(cmd_valid), 32'h0);
    check_stat("to.nack", 2'b10, 2'b00);
    tick();
    check("to.busy_clear", 32'(busy), 32'h0);
    cmd_ready = 1'b1;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
